// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit; fetch T0-T2, decode IR[31:27], execute T3-T7.
// Latency: one state per rising Clock edge; strobes are combinational from state, opcode and CON.
// Backpressure: Stop is honoured only at instruction boundaries (enters PAUSE); HALT holds until Clear.
// Ports: Clock/Clear (async active-low), IR, CON, Stop in; bus-out, register-in, memory, ALU-select
// strobes, Run and sticky Illegal out.
module control_sequencer (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        Stop,
  output logic        PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout, Cout,
  output logic        MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin,
  output logic        IncPC, Read, Write,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout, CONIn,
  output logic        ADD, SUB, AND, OR,
  output logic        Run,
  output logic        Illegal
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_PAUSE, S_HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110, OP_ADDI = 5'b01100, OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110, OP_BR   = 5'b10010, OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100, OP_IN   = 5'b10101, OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111, OP_MFLO = 5'b11000, OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [4:0] op;
  logic       unused_ir_bits;

  assign op             = IR[31:27];
  assign unused_ir_bits = ^IR[26:0];
  assign Illegal        = illegal_q;

  logic is_alu_r, is_alu_i, is_mem, is_legal;
  assign is_alu_r = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  assign is_alu_i = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  // ld, ldi and st share the same effective-address steps T3-T4
  assign is_mem   = (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
  assign is_legal = is_alu_r || is_alu_i || is_mem || (op == OP_BR) || (op == OP_JR) ||
                    (op == OP_JAL) || (op == OP_IN) || (op == OP_OUT) || (op == OP_MFHI) ||
                    (op == OP_MFLO) || (op == OP_NOP) || (op == OP_HALT);

  // Final step of the current instruction; nop and illegal opcodes end at T2.
  state_t last_step;
  always_comb begin
    last_step = S_T2;
    if (is_alu_r || is_alu_i || op == OP_LDI)                 last_step = S_T5;
    else if (op == OP_LD || op == OP_ST)                      last_step = S_T7;
    else if (op == OP_BR)                                     last_step = S_T6;
    else if (op == OP_JAL)                                    last_step = S_T4;
    else if (op == OP_JR || op == OP_IN || op == OP_OUT ||
             op == OP_MFHI || op == OP_MFLO)                  last_step = S_T3;
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q   <= S_RST;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_RST:   state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2: begin
        if (op == OP_HALT) state_d = S_HALT;
        else               state_d = S_T3;
        if (!is_legal) illegal_d = 1'b1;
      end
      S_T3:    state_d = S_T4;
      S_T4:    state_d = S_T5;
      S_T5:    state_d = S_T6;
      S_T6:    state_d = S_T7;
      S_T7:    state_d = S_T0;
      S_PAUSE: if (!Stop) state_d = S_T0;
      default: state_d = state_q;
    endcase
    // Instruction boundary overrides the linear step; Stop is only looked at here.
    if (state_q == last_step && state_q != S_RST && op != OP_HALT)
      state_d = Stop ? S_PAUSE : S_T0;
  end

  always_comb begin
    {PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout, Cout} = '0;
    {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin}     = '0;
    {IncPC, Read, Write}                                            = '0;
    {Gra, Grb, Grc, Rin, Rout, BAout, CONIn}                        = '0;
    {ADD, SUB, AND, OR}                                             = '0;
    Run = (state_q != S_RST) && (state_q != S_PAUSE) && (state_q != S_HALT);
    case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
      S_T1: begin Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (is_alu_r || is_alu_i) begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        else if (is_mem)          begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
        else if (op == OP_BR)     begin Gra = 1'b1; Rout = 1'b1; CONIn = 1'b1; end
        else if (op == OP_JR)     begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
        else if (op == OP_JAL)    begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
        else if (op == OP_IN)     begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (op == OP_OUT)    begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
        else if (op == OP_MFHI)   begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (op == OP_MFLO)   begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      end
      S_T4: begin
        if (is_alu_r || is_alu_i) begin
          Zin = 1'b1;
          if (is_alu_r) begin Grc = 1'b1; Rout = 1'b1; end
          else          Cout = 1'b1;
          ADD = (op == OP_ADD) || (op == OP_ADDI);
          SUB = (op == OP_SUB);
          AND = (op == OP_AND) || (op == OP_ANDI);
          OR  = (op == OP_OR)  || (op == OP_ORI);
        end
        else if (is_mem)       begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
        else if (op == OP_BR)  begin PCout = 1'b1; Yin = 1'b1; end
        else if (op == OP_JAL) begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
      end
      S_T5: begin
        if (is_alu_r || is_alu_i || op == OP_LDI) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (op == OP_LD || op == OP_ST)      begin Zlowout = 1'b1; MARin = 1'b1; end
        else if (op == OP_BR)                     begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
      end
      S_T6: begin
        if (op == OP_LD)      begin Read = 1'b1; MDRin = 1'b1; end
        // Read low steers the bus, not memory, into MDR
        else if (op == OP_ST) begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
        else if (op == OP_BR) begin Zlowout = 1'b1; PCin = CON; end
      end
      S_T7: begin
        if (op == OP_LD)      begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (op == OP_ST) Write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that drives the processor datapath's control inputs. A Moore state machine runs fetch (T0–T2) and then decodes the latched IR opcode to sequence T3–T7 for each instruction. It also handles conditional branches from the CON flip-flop, operator pause via `Stop`, and a terminal halt. It sits beside the datapath, sharing `Clock`, and is the sole source of every bus-out, register-in, memory and ALU-select strobe.

## Interface
- No parameters; opcode map fixed (IR[31:27]): 00000 ld, 00001 ldi, 00010 st, 00011 add, 00100 sub, 00101 and, 00110 or, 01100 addi, 01101 andi, 01110 ori, 10010 br, 10011 jr, 10100 jal, 10101 in, 10110 out, 10111 mfhi, 11000 mflo, 11001 nop, 11010 halt; all others = illegal.

Ports:
- Clock  in  1  rising-edge clock.
- Clear  in  1  asynchronous, active-low reset.
- IR  in  32  datapath instruction register.
- CON  in  1  CONFF branch-condition output.
- Stop  in  1  operator pause request.
- PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout, Cout  out  1 each  bus-source strobes.
- MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin  out  1 each  register-load strobes.
- IncPC, Read, Write  out  1 each  PC increment and memory strobes.
- Gra, Grb, Grc, Rin, Rout, BAout, CONIn  out  1 each  register-select strobes.
- ADD, SUB, AND, OR  out  1 each  ALU op select; at most one high.
- Run  out  1  high while executing.
- Illegal  out  1  sticky flag: an illegal opcode was decoded.

## Operation
- States: RST, T0–T7, PAUSE, HALT. The state register is the only sequential element besides `Illegal`.
- Outputs are decoded combinationally from state, IR[31:27] and (br T6 only) CON. Any strobe not listed for a state is 0.
- Fetch sequence:
  - T0: PCout, MARin, IncPC.
  - T1: Read, MDRin.
  - T2: MDRout, IRin.
- add/sub/and/or:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, op, Zin.
  - T5: Zlowout, Gra, Rin.
- addi/andi/ori:
  - T3 as above.
  - T4: Cout, op (ADD/AND/OR), Zin.
  - T5 as above.
- ld:
  - T3: Grb, BAout, Yin.
  - T4: Cout, ADD, Zin.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin.
  - T7: MDRout, Gra, Rin.
- ldi: T3–T4 as ld; T5: Zlowout, Gra, Rin.
- st:
  - T3–T5 as ld.
  - T6: Gra, Rout, MDRin (Read=0 selects bus).
  - T7: Write.
- br:
  - T3: Gra, Rout, CONIn.
  - T4: PCout, Yin.
  - T5: Cout, ADD, Zin.
  - T6: Zlowout, PCin gated by CON; no PCin when CON=0.
- jr: T3: Gra, Rout, PCin.
- jal:
  - T3: PCout, Grb, Rin (link).
  - T4: Gra, Rout, PCin.
- Single-step ops:
  - in, T3: InPortout, Gra, Rin.
  - out, T3: Gra, Rout, OutPortin.
  - mfhi, T3: HIout, Gra, Rin.
  - mflo, T3: LOout, Gra, Rin.
- nop and illegal: no T3. The last fetch state returns to T0. Illegal sets `Illegal` at the T2→T0 edge.
- halt: T2→HALT. HALT holds until Clear; all strobes 0, Run=0.
- Transitions:
  - RST→T0 on the first edge after Clear deasserts.
  - The final step of each instruction →T0, or →PAUSE if Stop=1 at that edge.
  - PAUSE→T0 on the first edge with Stop=0.
- Run = 1 in T0–T7; 0 in RST, PAUSE, HALT.

## Timing
- Clear low: state=RST immediately, all outputs 0, Illegal=0, Run=0. Clear asserted mid-instruction aborts with no further strobes.
- One state per rising edge; no wait states (memory is single-cycle).
- Cycles per instruction, fetch included:
  - ALU reg/imm: 6.
  - ld, st: 8.
  - ldi: 6.
  - br: 7.
  - jr, in, out, mfhi, mflo: 4.
  - jal: 5.
  - nop, illegal: 3.
- IR is sampled by decode only in T3–T7 and at the T2 exit edge. IR changes within T3–T7 are not expected.
- CON is sampled combinationally during br T6 only.
- Stop is evaluated only at instruction boundaries. It never truncates an instruction and is ignored in HALT.

## Test plan
- Reset/fetch: Clear low for 2 cycles, then high. Required: all outputs 0 and Run=0 during reset; RST, then T0 with PCout=MARin=IncPC=1; T1 Read=MDRin=1; T2 MDRout=IRin=1.
- add: IR=0x1A2B8000 (add r4,r5,r7). Required: T3 Grb/Rout/Yin; T4 Grc/Rout/ADD/Zin; T5 Zlowout/Gra/Rin; back to T0 at cycle 6.
- ld and st: ld takes 8 cycles with Read+MDRin in T6 and Gra+Rin in T7. st shows Write=1 only in T7 with Read=0.
- br: run twice, CON=1 then CON=0. Required: PCin=1 in T6 only when CON=1; Zlowout high in T6 both times; next state T0.
- Stop: raise Stop during ALU T4. Required: T5 completes, enter PAUSE with Run=0; drop Stop and T0 follows on the next edge.
- halt and illegal: opcode 11010 → HALT with Run=0 persisting 20 cycles; Stop ignored. Opcode 11111 → Illegal=1, returns to T0 after 3 cycles; Clear clears Illegal.
